// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word handshake and status bundle
interface uart_rx_if import uart_pkg::*; #(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop rx synchroniser with registered falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic       sync1;
    logic       prev;
    logic [2:0] warm;

    // warm[2] marks prev as holding a real pin sample rather than a reset value,
    // so a line already low at reset release is never taken as a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            prev  <= 1'b1;
            warm  <= 3'b000;
            fall  <= 1'b0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            prev  <= rx_s;
            warm  <= {warm[1:0], 1'b1};
            fall  <= warm[2] & prev & ~rx_s;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start detect, mid-bit sampling, valid/ack output
module uart_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 fall;
    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 shift_en;
    logic                 load;
    logic                 ferr;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // START samples at half a bit, so every later sample lands mid-bit and STOP
    // leaves half a bit early, ready for a back-to-back start edge.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        load     = 1'b0;
        ferr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) state_d = START;
            end
            START: begin
                if (cnt == CNT_HALF) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_en = 1'b1;
                    if (idx == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    load    = rx_s;
                    ferr    = ~rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            cnt <= (state_d != state_q) ? '0 : cnt + 1'b1;
            if (state_q == START) begin
                idx <= '0;
            end else if (shift_en) begin
                idx   <= idx + 1'b1;
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= ferr;
            if (load) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
                if (bus.rx_valid && !bus.rx_ack) bus.overrun <= 1'b1;
            end else if (bus.rx_ack && bus.rx_valid) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int LAT = 156;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One entry per frame on the line: kind 1 = good word, 2 = bad stop bit, 0 = glitch.
    // ev is the clk edge where the word (or error) appears; busy spans [lo, hi).
    typedef struct {
        int         kind;
        int         ev;
        logic [7:0] data;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_ld    = 1'b0;
    logic [7:0] m_nd    = 8'h00;
    logic       ack_prev = 1'b0;

    always @(negedge clk) begin
        m_ferr = 1'b0;
        m_busy = 1'b0;
        m_ld   = 1'b0;
        m_nd   = 8'h00;
        if (!rst) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            q.delete();
        end else begin
            foreach (q[i]) begin
                if (q[i].ev == cyc) begin
                    if (q[i].kind == 1) begin
                        m_ld = 1'b1;
                        m_nd = q[i].data;
                    end else if (q[i].kind == 2) begin
                        m_ferr = 1'b1;
                    end
                end
                if (cyc >= q[i].lo && cyc < q[i].hi) m_busy = 1'b1;
            end
            if (m_ld) begin
                if (m_valid && !ack_prev) m_ovr = 1'b1;
                m_data  = m_nd;
                m_valid = 1'b1;
            end else if (ack_prev && m_valid) begin
                m_valid = 1'b0;
            end
        end
        check("cyc_rx_data",   bus.rx_data,   m_data);
        check("cyc_rx_valid",  bus.rx_valid,  m_valid);
        check("cyc_frame_err", bus.frame_err, m_ferr);
        check("cyc_overrun",   bus.overrun,   m_ovr);
        check("cyc_busy",      bus.busy,      m_busy);
        ack_prev = bus.rx_ack;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        q.push_back('{stop_ok ? 1 : 2, cyc + LAT, d, cyc + 4, cyc + LAT});
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b0;
    endtask

    int nferr = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.rx_ack = 1'b0;
        @(negedge clk);
        check("reset_valid", bus.rx_valid, 0);
        check("reset_data",  bus.rx_data,  0);
        check("reset_busy",  bus.busy,     0);
        idle(3);
        rst = 1'b1;
        idle(20);

        // 0xA5: word appears on edge k+156 and not one edge earlier
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                check("lat_valid_early", bus.rx_valid, 0);
                @(negedge clk);
                check("lat_valid",  bus.rx_valid,  1);
                check("lat_data",   bus.rx_data,   8'hA5);
                check("lat_ferr",   bus.frame_err, 0);
            end
        join
        idle(5);
        ack_pulse();
        @(negedge clk);
        check("ack_clears_valid", bus.rx_valid, 0);
        idle(10);

        // 4-cycle low glitch
        q.push_back('{0, -1, 8'h00, cyc + 4, cyc + 12});
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(20);
        check("glitch_busy",  bus.busy,     0);
        check("glitch_valid", bus.rx_valid, 0);
        check("glitch_data",  bus.rx_data,  8'hA5);

        // 0x3C with a zero stop bit
        fork
            send_frame(8'h3C, 1'b0);
            begin
                repeat (165) begin
                    @(negedge clk);
                    if (bus.frame_err) nferr++;
                end
            end
        join
        idle(5);
        check("ferr_pulses", nferr, 1);
        check("ferr_data",   bus.rx_data,  8'hA5);
        check("ferr_valid",  bus.rx_valid, 0);
        idle(10);

        // back-to-back 0x11, 0x22 with no ack
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        check("ovr_data",  bus.rx_data,  8'h22);
        check("ovr_valid", bus.rx_valid, 1);
        check("ovr_flag",  bus.overrun,  1);
        ack_pulse();
        idle(5);
        check("ovr_sticky", bus.overrun,  1);
        check("ovr_acked",  bus.rx_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ovr_reset", bus.overrun, 0);
        idle(2);
        rst = 1'b1;
        idle(10);

        // 0x55 then 0xAA with ack in 0xAA's load cycle
        send_frame(8'h55, 1'b1);
        fork
            send_frame(8'hAA, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                ack_pulse();
                @(negedge clk);
                check("ackload_valid", bus.rx_valid, 1);
                check("ackload_data",  bus.rx_data,  8'hAA);
                check("ackload_ovr",   bus.overrun,  0);
            end
        join
        idle(10);

        // reset during data bit 3 of 0xF0 (bits 0..3 are all zero)
        q.push_back('{1, cyc + LAT, 8'hF0, cyc + 4, cyc + LAT});
        rx = 1'b0;
        idle(72);
        check("abort_busy", bus.busy, 1);
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        check("abort_rst_data",  bus.rx_data,   0);
        check("abort_rst_valid", bus.rx_valid,  0);
        check("abort_rst_ferr",  bus.frame_err, 0);
        check("abort_rst_ovr",   bus.overrun,   0);
        check("abort_rst_busy",  bus.busy,      0);
        idle(5);
        rst = 1'b1;
        idle(20);
        check("abort_idle_busy", bus.busy, 0);
        send_frame(8'h81, 1'b1);
        idle(5);
        check("post_rst_data",  bus.rx_data,  8'h81);
        check("post_rst_valid", bus.rx_valid, 1);
        check("post_rst_ovr",   bus.overrun,  0);

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
